// File: rtl/branch_pkg.sv
// Shared encodings for the branch unit: status flag bit positions, branch
// condition codes and the evaluation FSM states.
package branch_pkg;

   localparam int ZF = 2;
   localparam int VF = 1;
   localparam int NF = 0;

   typedef enum logic [2:0] {
      B   = 3'b000,
      BEQ = 3'b001,
      BNE = 3'b010,
      BLT = 3'b011,
      BLE = 3'b100
   } cond_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/branch_unit_cond_eval.sv
// Pure combinational condition check: decides take from {Z,V,N} flags and a
// condition code, and flags the reserved codes as illegal.
module cond_eval
   import branch_pkg::*;
(
   input  logic [2:0] flags_i,
   input  logic [2:0] cond_i,
   output logic       take_o,
   output logic       cond_err_o
);

   logic z, v, n, lt;

   assign z  = flags_i[ZF];
   assign v  = flags_i[VF];
   assign n  = flags_i[NF];
   assign lt = n ^ v;

   always_comb begin
      take_o     = 1'b0;
      cond_err_o = 1'b0;
      case (cond_i)
         B:       take_o = 1'b1;
         BEQ:     take_o = z;
         BNE:     take_o = ~z;
         BLT:     take_o = lt;
         BLE:     take_o = lt | z;
         // Reserved codes never branch.
         default: cond_err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: status register, a three-state IDLE/EVAL/DONE
// evaluator with fixed latency, and the next-PC adder.
module branch_unit
   import branch_pkg::*;
#(
   parameter int PC_W   = 9,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              loads,
   input  logic [2:0]        Z_in,
   input  logic              br_req,
   input  logic [2:0]        cond,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [DATA_W-1:0] sximm8,
   output logic [2:0]        status,
   output logic              br_busy,
   output logic              br_done,
   output logic              take,
   output logic [PC_W-1:0]   pc_next,
   output logic              cond_err,
   output logic [1:0]        state_dbg
);

   state_e          state_q, state_d;
   logic            accept;
   logic [2:0]      status_q;
   logic [2:0]      flags_q;
   logic [2:0]      cond_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] off_q;
   logic            take_q;
   logic            cond_err_q;
   logic [PC_W-1:0] pc_next_q;
   logic            eval_take;
   logic            eval_err;
   logic [PC_W-1:0] pc_plus1;
   logic [PC_W-1:0] pc_target;

   // Only the low PC_W offset bits matter once the sum wraps mod 2^PC_W.
   generate
      if (DATA_W > PC_W) begin : g_off_hi
         logic unused_off_hi;
         assign unused_off_hi = ^sximm8[DATA_W-1:PC_W];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (br_req) begin
               accept  = 1'b1;
               state_d = EVAL;
            end
         end
         EVAL:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         status_q <= 3'b000;
      end else if (loads) begin
         status_q <= Z_in;
      end
   end

   // Flags written in the accepting cycle are forwarded so a compare and its
   // branch may issue together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= 3'b000;
         cond_q  <= 3'b000;
         pc_q    <= '0;
         off_q   <= '0;
      end else if (accept) begin
         flags_q <= loads ? Z_in : status_q;
         cond_q  <= cond;
         pc_q    <= pc_in;
         off_q   <= sximm8[PC_W-1:0];
      end
   end

   cond_eval u_cond_eval (
      .flags_i    (flags_q),
      .cond_i     (cond_q),
      .take_o     (eval_take),
      .cond_err_o (eval_err)
   );

   assign pc_plus1  = pc_q + PC_W'(1);
   assign pc_target = pc_plus1 + off_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         take_q     <= 1'b0;
         cond_err_q <= 1'b0;
         pc_next_q  <= '0;
      end else if (state_q == EVAL) begin
         take_q     <= eval_take;
         cond_err_q <= eval_err;
         pc_next_q  <= eval_take ? pc_target : pc_plus1;
      end
   end

   assign status    = status_q;
   assign br_busy   = (state_q != IDLE);
   assign br_done   = (state_q == DONE);
   assign take      = take_q;
   assign pc_next   = pc_next_q;
   assign cond_err  = cond_err_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed and randomized checks of branch_unit against a flag/arithmetic
// reference model of the branch rules.
module tb_branch_unit;
   import branch_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        loads;
   logic [2:0]  Z_in;
   logic        br_req;
   logic [2:0]  cond;
   logic [8:0]  pc_in;
   logic [15:0] sximm8;
   logic [2:0]  status;
   logic        br_busy;
   logic        br_done;
   logic        take;
   logic [8:0]  pc_next;
   logic        cond_err;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_pass   = 0;
   logic [2:0] m_status;
   logic [8:0] m_pc_next;

   always #5 clk = ~clk;

   branch_unit #(.PC_W(9), .DATA_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .loads     (loads),
      .Z_in      (Z_in),
      .br_req    (br_req),
      .cond      (cond),
      .pc_in     (pc_in),
      .sximm8    (sximm8),
      .status    (status),
      .br_busy   (br_busy),
      .br_done   (br_done),
      .take      (take),
      .pc_next   (pc_next),
      .cond_err  (cond_err),
      .state_dbg (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Branch rules written straight from the flag definitions.
   function automatic void ref_branch(input logic [2:0] f, input int c, input int pc, input int off,
                                      output logic t, output logic e, output logic [8:0] npc);
      logic z, v, n;
      int sum;
      z = f[2]; v = f[1]; n = f[0];
      e = (c >= 5);
      if (c == 0)      t = 1'b1;
      else if (c == 1) t = z;
      else if (c == 2) t = !z;
      else if (c == 3) t = (n != v);
      else if (c == 4) t = (n != v) || z;
      else             t = 1'b0;
      sum = pc + 1 + (t ? (off % 512) : 0);
      npc = 9'(sum % 512);
   endfunction

   task automatic load_status(input logic [2:0] z);
      @(negedge clk);
      loads = 1'b1; Z_in = z;
      @(posedge clk); #1;
      loads = 1'b0;
      m_status = z;
   endtask

   task automatic run_branch(input string tag, input logic [2:0] c, input logic [8:0] pc,
                             input logic [15:0] off, input logic ld, input logic [2:0] z);
      logic [2:0] flags;
      logic et, ee;
      logic [8:0] epc;
      int lat;
      @(negedge clk);
      br_req = 1'b1; cond = c; pc_in = pc; sximm8 = off; loads = ld; Z_in = z;
      flags = ld ? z : m_status;
      if (ld) m_status = z;
      ref_branch(flags, int'(c), int'(pc), int'(off[8:0]), et, ee, epc);
      @(posedge clk); #1;
      br_req = 1'b0; loads = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) check({tag, ".busy"}, 32'(br_busy), 32'(1));
      end while (!br_done && lat < 6);
      check({tag, ".latency"}, 32'(lat), 32'(2));
      check({tag, ".take"}, 32'(take), 32'(et));
      check({tag, ".pc_next"}, 32'(pc_next), 32'(epc));
      check({tag, ".cond_err"}, 32'(cond_err), 32'(ee));
      check({tag, ".status"}, 32'(status), 32'(m_status));
      m_pc_next = epc;
      @(negedge clk);
      check({tag, ".done_low"}, 32'(br_done), 32'(0));
      check({tag, ".pc_hold"}, 32'(pc_next), 32'(epc));
   endtask

   initial begin
      int pulses;
      reset = 1'b1; loads = 1'b0; Z_in = 3'b000; br_req = 1'b0;
      cond = 3'b000; pc_in = '0; sximm8 = '0;
      m_status = 3'b000; m_pc_next = '0;

      // Reset state.
      #2;
      check("rst.status", 32'(status), 32'(0));
      check("rst.busy", 32'(br_busy), 32'(0));
      check("rst.done", 32'(br_done), 32'(0));
      check("rst.take", 32'(take), 32'(0));
      check("rst.pc_next", 32'(pc_next), 32'(0));
      check("rst.cond_err", 32'(cond_err), 32'(0));
      check("rst.state", 32'(state_dbg), 32'(IDLE));
      @(negedge clk); @(negedge clk);
      reset = 1'b0;

      // Status load then BEQ.
      load_status(3'b100);
      check("load.status", 32'(status), 32'(4));
      run_branch("beq", 3'b001, 9'd10, 16'd5, 1'b0, 3'b000);
      check("beq.pc16", 32'(pc_next), 32'(16));

      // Forwarding of flags loaded in the accepting cycle.
      load_status(3'b000);
      run_branch("fwd", 3'b011, 9'd20, 16'hFFFD, 1'b1, 3'b001);
      check("fwd.pc18", 32'(pc_next), 32'(18));
      check("fwd.status", 32'(status), 32'(1));

      // PC wrap-around.
      run_branch("wrap_b", 3'b000, 9'd510, 16'd4, 1'b0, 3'b000);
      check("wrap_b.pc3", 32'(pc_next), 32'(3));
      load_status(3'b100);
      run_branch("wrap_bne", 3'b010, 9'd511, 16'd7, 1'b0, 3'b000);
      check("wrap_bne.pc0", 32'(pc_next), 32'(0));

      // Held request: second accept only after the DONE cycle.
      @(negedge clk);
      br_req = 1'b1; cond = 3'b000; pc_in = 9'd100; sximm8 = 16'd2;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 6) br_req = 1'b0;
         @(posedge clk); #1;
         if (br_done) pulses++;
         @(negedge clk);
      end
      check("held.pulses", 32'(pulses), 32'(2));
      check("held.idle", 32'(br_busy), 32'(0));
      m_pc_next = 9'd103;

      // Illegal condition code.
      run_branch("illegal", 3'b110, 9'd40, 16'd9, 1'b0, 3'b000);
      check("illegal.pc41", 32'(pc_next), 32'(41));

      // Reset while in EVAL aborts the branch.
      load_status(3'b010);
      @(negedge clk);
      br_req = 1'b1; cond = 3'b000; pc_in = 9'd60; sximm8 = 16'd1;
      @(posedge clk); #1;
      br_req = 1'b0;
      check("abort.eval", 32'(state_dbg), 32'(EVAL));
      #1 reset = 1'b1;
      #1;
      check("abort.busy", 32'(br_busy), 32'(0));
      check("abort.status", 32'(status), 32'(0));
      check("abort.done", 32'(br_done), 32'(0));
      pulses = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (br_done) pulses++;
      end
      #1 reset = 1'b0;
      m_status = 3'b000;
      repeat (3) begin
         @(posedge clk); #1;
         if (br_done) pulses++;
      end
      check("abort.nodone", 32'(pulses), 32'(0));

      // First request right after reset release.
      reset = 1'b1; #3; reset = 1'b0;
      run_branch("post_rst", 3'b001, 9'd7, 16'd3, 1'b1, 3'b100);

      // Randomized branches against the reference model.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) load_status(3'($urandom_range(0, 7)));
         run_branch($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 9'($urandom_range(0, 511)),
                    16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
